// File: rtl/ntt_layer_scheduler.sv
// Address/twiddle sequencer for an in-place Cooley-Tukey NTT over a dual-port RAM.
// Issues one butterfly per cycle, drains the datapath between layers, replays write-back addresses.
module ntt_layer_scheduler #(
  parameter int unsigned N      = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LAYERS = 7,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr_a,
  output logic [ADDR_W-1:0] o_rd_addr_b,
  output logic              o_bf_start,
  output logic [ADDR_W-2:0] o_twiddle_idx,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr_a,
  output logic [ADDR_W-1:0] o_wr_addr_b,
  output logic [2:0]        o_layer
);

  localparam int unsigned       D          = RD_LAT + BF_LAT;
  localparam int unsigned       DCNT_W     = $clog2(D) + 1;
  localparam int unsigned       RW         = 3 * ADDR_W;
  localparam int unsigned       WW         = 2 * ADDR_W + 1;
  localparam logic [ADDR_W-1:0] HALF       = ADDR_W'(N / 2);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
  localparam logic [2:0]        LAST_LAYER = 3'(LAYERS - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(D - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_j;
  logic [ADDR_W-1:0] r_grp;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_cnt;
  logic [DCNT_W-1:0] r_dcnt;
  logic [2:0]        r_layer;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_a;
  logic [ADDR_W-1:0] r_rd_b;
  logic [ADDR_W-2:0] r_rd_k;

  logic              w_issue;
  logic              w_wrap;
  logic              w_layer_end;
  logic [ADDR_W-1:0] w_j_inc;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_grp_nxt;

  assign w_issue     = (r_state == StRun) || ((r_state == StIdle) && i_start);
  assign w_j_inc     = r_j + ONE;
  assign w_wrap      = (w_j_inc == (r_grp + r_len));
  assign w_grp_nxt   = r_grp + (r_len << 1);
  assign w_cnt_inc   = r_cnt + ONE;
  assign w_layer_end = (w_cnt_inc == HALF);

  // Pointers (j, grp, len, k) always hold the next pair to issue, so IDLE+start issues at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_j     <= '0;
      r_grp   <= '0;
      r_len   <= HALF;
      r_k     <= ONE;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_layer <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_rd_k  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= w_issue;
      r_rd_a  <= w_issue ? r_j : '0;
      r_rd_b  <= w_issue ? (r_j + r_len) : '0;
      r_rd_k  <= w_issue ? r_k[ADDR_W-2:0] : '0;
      if (w_issue) begin
        r_busy  <= 1'b1;
        r_cnt   <= w_cnt_inc;
        r_dcnt  <= '0;
        r_state <= w_layer_end ? StDrain : StRun;
        if (w_wrap) begin
          r_grp <= w_grp_nxt;
          r_j   <= w_grp_nxt;
          r_k   <= r_k + ONE;
        end else begin
          r_j <= w_j_inc;
        end
      end else begin
        case (r_state)
          StDrain: begin
            // Hold off reads until every write of this layer has landed.
            if (r_dcnt == DCNT_LAST) begin
              r_cnt <= '0;
              r_j   <= '0;
              r_grp <= '0;
              if (r_layer == LAST_LAYER) begin
                r_state <= StFin;
              end else begin
                r_layer <= r_layer + 3'd1;
                r_len   <= r_len >> 1;
                r_state <= StRun;
              end
            end else begin
              r_dcnt <= r_dcnt + DCNT_W'(1);
            end
          end
          StFin: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_layer <= '0;
            r_len   <= HALF;
            r_k     <= ONE;
            r_state <= StIdle;
          end
          default: begin
          end
        endcase
      end
    end
  end

  logic [RD_LAT-1:0][RW-1:0] r_rd_pipe;
  logic [BF_LAT-1:0][WW-1:0] r_wr_pipe;
  logic [RW-1:0]             w_bf_word;
  logic [WW-1:0]             w_wr_word;

  assign w_bf_word = r_rd_pipe[RD_LAT-1];
  assign w_wr_word = r_wr_pipe[BF_LAT-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_pipe <= '0;
      r_wr_pipe <= '0;
    end else begin
      r_rd_pipe[0] <= {r_rd_en, r_rd_a, r_rd_b, r_rd_k};
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
      r_wr_pipe[0] <= w_bf_word[RW-1 -: WW];
      for (int i = 1; i < int'(BF_LAT); i++) begin
        r_wr_pipe[i] <= r_wr_pipe[i-1];
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rd_en       = r_rd_en;
  assign o_rd_addr_a   = r_rd_a;
  assign o_rd_addr_b   = r_rd_b;
  assign o_layer       = r_layer;
  assign o_bf_start    = w_bf_word[RW-1];
  assign o_twiddle_idx = w_bf_word[ADDR_W-2:0];
  assign o_wr_en       = w_wr_word[WW-1];
  assign o_wr_addr_a   = w_wr_word[WW-2 -: ADDR_W];
  assign o_wr_addr_b   = w_wr_word[ADDR_W-1:0];

endmodule

// File: tb/tb_ntt_layer_scheduler.sv
// Bench for ntt_layer_scheduler: cycle model of the issue schedule plus a RAM/butterfly
// scoreboard compared against a golden Kyber NTT of x[i] = i.
module tb_ntt_layer_scheduler;
  localparam int N        = 256;
  localparam int Q        = 3329;
  localparam int DONE_CYC = 932;
  localparam int NISSUE   = 896;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, rd_en, bf_start, wr_en;
  logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [6:0] twiddle_idx;
  logic [2:0] layer;

  always #5 clk = ~clk;

  ntt_layer_scheduler #(
    .N(256), .ADDR_W(8), .LAYERS(7), .RD_LAT(1), .BF_LAT(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_rd_en(rd_en), .o_rd_addr_a(rd_addr_a), .o_rd_addr_b(rd_addr_b),
    .o_bf_start(bf_start), .o_twiddle_idx(twiddle_idx),
    .o_wr_en(wr_en), .o_wr_addr_a(wr_addr_a), .o_wr_addr_b(wr_addr_b),
    .o_layer(layer)
  );

  int n_checks = 0;
  int n_errs = 0;
  int mt = 0;  // model cycle within a transform; 0 = idle
  int ex_rd[940], ex_a[940], ex_b[940], ex_k[940], ex_layer[940];
  int zeta[128], gold[256], ram[256], pend[256];
  int qa[$], qb[$], ra[$], rb[$];
  int n_rd, n_bf, n_wr, hz_errs, dut_cyc;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Transform timeline: start seen in idle at an edge -> cycle 1 next; done cycle is idle again.
  always @(posedge clk or posedge rst) begin
    if (rst) mt <= 0;
    else if ((mt == 0 || mt == DONE_CYC) && start) mt <= 1;
    else if (mt == DONE_CYC) mt <= 0;
    else if (mt > 0) mt <= mt + 1;
  end

  initial begin : compare
    int c, kk, len, e, p, z, t, a, b, ib, iw, mism;
    c = 1;
    kk = 1;
    for (int l = 0; l < 7; l++) begin
      len = 128 >> l;
      for (int st = 0; st < N; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          ex_rd[c] = 1; ex_a[c] = j; ex_b[c] = j + len; ex_k[c] = kk; ex_layer[c] = l;
          c++;
        end
        kk++;
      end
      c += 5;
    end
    for (int i = 0; i < 128; i++) begin
      e = 0;
      for (int bb = 0; bb < 7; bb++) if (i[bb]) e |= 1 << (6 - bb);
      p = 1;
      for (int x = 0; x < e; x++) p = (p * 17) % Q;
      zeta[i] = p;
    end
    for (int i = 0; i < N; i++) gold[i] = i;
    kk = 1;
    for (len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < N; st += 2 * len) begin
        z = zeta[kk];
        kk++;
        for (int j = st; j < st + len; j++) begin
          t = (z * gold[j + len]) % Q;
          gold[j + len] = (gold[j] - t + Q) % Q;
          gold[j] = (gold[j] + t) % Q;
        end
      end
    end
    chk("model_done_cycle", c, DONE_CYC);
    chk("model_zeta1", zeta[1], 1729);
    chk("model_c1_a", ex_a[1], 0);
    chk("model_c1_b", ex_b[1], 128);
    chk("model_c1_k", ex_k[1], 1);
    chk("model_c128_a", ex_a[128], 127);
    chk("model_c128_b", ex_b[128], 255);
    chk("model_c129_rd", ex_rd[129], 0);
    chk("model_c133_rd", ex_rd[133], 0);
    chk("model_l1_first_b", ex_b[134], 64);
    chk("model_l1_first_k", ex_k[134], 2);
    chk("model_l1_i64_a", ex_a[198], 128);
    chk("model_l1_i64_b", ex_b[198], 192);
    chk("model_l1_i64_k", ex_k[198], 3);
    chk("model_l6_last_a", ex_a[926], 253);
    chk("model_l6_last_b", ex_b[926], 255);
    chk("model_l6_last_k", ex_k[926], 127);

    forever begin
      @(negedge clk);
      ib = mt - 1;
      iw = mt - 5;
      if (rst || mt == 1) begin
        qa.delete(); qb.delete(); ra.delete(); rb.delete();
        for (int i = 0; i < N; i++) begin
          pend[i] = 0;
          ram[i] = i;
        end
        n_rd = 0; n_bf = 0; n_wr = 0; hz_errs = 0;
      end
      chk("rd_en", int'(rd_en), ex_rd[mt]);
      chk("rd_addr_a", int'(rd_addr_a), ex_a[mt]);
      chk("rd_addr_b", int'(rd_addr_b), ex_b[mt]);
      chk("bf_start", int'(bf_start), (ib >= 1) ? ex_rd[ib] : 0);
      chk("twiddle_idx", int'(twiddle_idx), (ib >= 1) ? ex_k[ib] : 0);
      chk("wr_en", int'(wr_en), (iw >= 1) ? ex_rd[iw] : 0);
      chk("wr_addr_a", int'(wr_addr_a), (iw >= 1) ? ex_a[iw] : 0);
      chk("wr_addr_b", int'(wr_addr_b), (iw >= 1) ? ex_b[iw] : 0);
      chk("busy", int'(busy), (mt >= 1 && mt < DONE_CYC) ? 1 : 0);
      chk("done", int'(done), (mt == DONE_CYC) ? 1 : 0);
      if (ex_rd[mt] != 0 || rst) chk("layer", int'(layer), ex_layer[mt]);

      if (wr_en) begin
        n_wr++;
        a = int'(wr_addr_a);
        b = int'(wr_addr_b);
        if (ra.size() > 0) begin
          ram[a] = ra.pop_front();
          ram[b] = rb.pop_front();
          pend[a]--;
          pend[b]--;
        end else hz_errs++;
      end
      if (bf_start) begin
        n_bf++;
        if (qa.size() > 0) begin
          a = qa.pop_front();
          b = qb.pop_front();
          t = (zeta[int'(twiddle_idx)] * b) % Q;
          ra.push_back((a + t) % Q);
          rb.push_back((a - t + Q) % Q);
        end else hz_errs++;
      end
      if (rd_en) begin
        n_rd++;
        a = int'(rd_addr_a);
        b = int'(rd_addr_b);
        if (pend[a] != 0 || pend[b] != 0) hz_errs++;
        qa.push_back(ram[a]);
        qb.push_back(ram[b]);
        pend[a]++;
        pend[b]++;
      end

      if (rst) dut_cyc = 0;
      else if (dut_cyc == 0 && rd_en) dut_cyc = 1;
      else if (dut_cyc > 0) dut_cyc++;
      if (done) begin
        chk("done_cycle", dut_cyc, DONE_CYC);
        dut_cyc = 0;
      end

      if (mt == DONE_CYC) begin
        chk("rd_count", n_rd, NISSUE);
        chk("bf_count", n_bf, NISSUE);
        chk("wr_count", n_wr, NISSUE);
        chk("hazard_errors", hz_errs, 0);
        mism = 0;
        for (int i = 0; i < N; i++) if (ram[i] != gold[i]) mism++;
        chk("ntt_mismatch_count", mism, 0);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    // Full run with a stray start pulse mid-RUN.
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (49) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (900) @(posedge clk);

    // Abort at cycle 300, then a clean second run.
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (299) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (950) @(posedge clk);

    // Start held high: back-to-back transforms from IDLE only.
    #1 start = 1'b1;
    repeat (1000) @(posedge clk);
    #1 start = 1'b0;
    repeat (950) @(posedge clk);

    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
